ps2_rx_fifo: RTL and testbench

//  Parametrised PS/2 device-to-host receiver: successor of the single-byte PS/2 receiver.

---
 rtl/ps2_rx_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// -----------------------------------------------------------------------------
// ps2_rx_fifo
//
// PS/2 device-to-host receiver with a receive FIFO. Both PS/2 pins are
// sampled in the system clock domain through flip-flop synchronisers. The
// PS/2 clock is glitch-filtered, and its falling edges step a frame FSM
// through start, 8 data bits (LSB first), odd parity and stop. Each frame
// becomes a {err, byte} FIFO entry. The consumer reads entries through the
// data_req / data_ack handshake.
//
// Optional feature (compile-time macro):
//   PS2_RX_TIMEOUT_EN : when defined, a watchdog aborts a partial frame after
//                       TIMEOUT_CYCLES clk cycles without a PS/2 falling edge.
//                       When undefined, no watchdog logic is built.
//
// Parameters:
//   FIFO_DEPTH     : receive FIFO entries (power of two, >= 2)
//   SYNC_STAGES    : synchroniser flops per pin (>= 2)
//   FILTER_LEN     : consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYCLES : watchdog limit in clk cycles (only with PS2_RX_TIMEOUT_EN)
//
// Ports:
//   clk        in  : system clock, all logic on posedge
//   rst_n      in  : asynchronous reset, active low
//   data_pin   in  : PS/2 data line (asynchronous)
//   clk_pin    in  : PS/2 clock line (asynchronous)
//   data_req   in  : consumer requests the next entry
//   data       out : popped byte, held until the next pop
//   data_err   out : popped entry had a parity or stop-bit error
//   data_ack   out : one-cycle pulse, data/data_err valid
//   fifo_count out : entries currently queued
//   overflow   out : sticky, a complete frame was dropped on a full FIFO
//   ovf_clr    in  : synchronous clear of overflow
// -----------------------------------------------------------------------------
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              data_pin,
   input  logic                              clk_pin,
   input  logic                              data_req,
   output logic [7:0]                        data,
   output logic                              data_err,
   output logic                              data_ack,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow,
   input  logic                              ovf_clr
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);

   // Elaboration-time guard against unsupported parameter values.
   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
          SYNC_STAGES < 2 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 1) begin : g_param_error
         $error("ps2_rx_fifo: unsupported parameter value");
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Pin synchronisers. They reset to 1, which is the idle level of both lines.
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] data_sync_reg;
   logic                   clk_s;
   logic                   data_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_reg  <= '1;
         data_sync_reg <= '1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], clk_pin};
         data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], data_pin};
      end
   end

   assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
   assign data_s = data_sync_reg[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Clock glitch filter. flt_cnt_reg counts consecutive samples that
   // disagree with the filtered level. The level flips on the FILTER_LEN-th
   // disagreeing sample. fe is asserted in that same cycle, so the data
   // sample taken in the fe cycle is the one aligned with the edge.
   // ---------------------------------------------------------------------
   logic             filt_reg;
   logic [FLT_W-1:0] flt_cnt_reg;
   logic             flt_hit;
   logic             fe;

   assign flt_hit = (clk_s != filt_reg) && (flt_cnt_reg == FLT_W'(FILTER_LEN - 1));
   assign fe      = flt_hit && filt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_reg    <= 1'b1;
         flt_cnt_reg <= '0;
      end else if (clk_s != filt_reg) begin
         if (flt_hit) begin
            filt_reg    <= clk_s;
            flt_cnt_reg <= '0;
         end else begin
            flt_cnt_reg <= flt_cnt_reg + FLT_W'(1);
         end
      end else begin
         flt_cnt_reg <= '0;
      end
   end

   // ---------------------------------------------------------------------
   // Frame FSM. The completed entry is registered and pushed one cycle
   // after the stop-bit edge.
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t     state_reg;
   logic [2:0] bit_cnt_reg;
   logic [7:0] shift_reg;
   logic       par_reg;
   logic       push_reg;
   logic [7:0] push_data_reg;
   logic       push_err_reg;
`ifdef PS2_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_reg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         par_reg       <= 1'b0;
         push_reg      <= 1'b0;
         push_data_reg <= '0;
         push_err_reg  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
         to_cnt_reg    <= '0;
`endif
      end else begin
         push_reg <= 1'b0;
         if (fe) begin
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
            case (state_reg)
               IDLE: begin
                  // A 1 on the data line is not a start bit and is ignored.
                  if (!data_s) begin
                     state_reg   <= DATA;
                     bit_cnt_reg <= '0;
                  end
               end
               DATA: begin
                  shift_reg   <= {data_s, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7)
                     state_reg <= PARITY;
               end
               PARITY: begin
                  par_reg   <= data_s;
                  state_reg <= STOP;
               end
               STOP: begin
                  push_reg      <= 1'b1;
                  push_data_reg <= shift_reg;
                  // Odd parity: byte bits plus parity must have an odd count of ones.
                  push_err_reg  <= ~(^shift_reg ^ par_reg) | ~data_s;
                  state_reg     <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
`ifdef PS2_RX_TIMEOUT_EN
         else if (state_reg != IDLE) begin
            if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_reg  <= IDLE;
               to_cnt_reg <= '0;
            end else begin
               to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
         end else begin
            to_cnt_reg <= '0;
         end
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Receive FIFO. The storage array has no reset so it can map to RAM.
   // The read is registered straight into the data/data_err outputs.
   // ---------------------------------------------------------------------
   logic [8:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             pop;
   logic             full;
   logic             push_ok;

   // The !data_ack term forces a gap cycle after every pop.
   assign pop     = data_req && !data_ack && (count_reg != '0);
   assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot that a full FIFO needs.
   assign push_ok = push_reg && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= {push_err_reg, push_data_reg};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         data       <= '0;
         data_err   <= 1'b0;
         data_ack   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         data_ack <= pop;
         if (pop) begin
            {data_err, data} <= mem[rd_ptr_reg];
            rd_ptr_reg       <= rd_ptr_reg + PTR_W'(1);
         end
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         // A new drop takes priority over a clear in the same cycle.
         if (push_reg && !push_ok)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   assign fifo_count = count_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx_fifo
//
// Self-checking bench for ps2_rx_fifo (FIFO_DEPTH=4, FILTER_LEN=4, PS/2 bit
// period 40 clk). Expected {err,byte} entries are queued when a frame is
// driven. A monitor pops and compares them on every data_ack. The watchdog
// scenario is built only when PS2_RX_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_ps2_rx_fifo;

   localparam int DEPTH = 4;
   localparam int TO    = 1000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       data_pin = 1'b1;
   logic       clk_pin = 1'b1;
   logic       data_req = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] data;
   logic       data_err;
   logic       data_ack;
   logic [2:0] fifo_count;
   logic       overflow;

   int         n_checks = 0;
   int         n_pass = 0;
   int         ack_total = 0;
   logic       prev_ack = 1'b0;
   logic [8:0] exp_q [$];

   always #5 clk = ~clk;

   ps2_rx_fifo #(
      .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .data_pin(data_pin), .clk_pin(clk_pin),
      .data_req(data_req), .data(data), .data_err(data_err), .data_ack(data_ack),
      .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard monitor: each ack must match the oldest expected entry and
   // must never follow another ack directly.
   always @(negedge clk) begin : mon
      logic [8:0] e;
      if (data_ack) begin
         ack_total++;
         check("ack_gap", {31'd0, prev_ack}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("data", {24'd0, data}, {24'd0, e[7:0]});
            check("data_err", {31'd0, data_err}, {31'd0, e[8]});
            $display("rx data=0x%02h err=%0b exp=0x%02h/%0b", data, data_err, e[7:0], e[8]);
         end
      end
      prev_ack = data_ack;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      data_pin = b;
      tick(10);
      clk_pin = 1'b0;
      tick(20);
      clk_pin = 1'b1;
      tick(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b) ^ bad_par);
      send_bit(stop);
      data_pin = 1'b1;
      tick(5);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(b[i]);
   endtask

   task automatic read_one(input string tag);
      int a0;
      a0 = ack_total;
      data_req = 1'b1;
      tick(1);
      data_req = 1'b0;
      tick(2);
      check(tag, ack_total - a0, 32'd1);
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int a0;
      // Reset state
      tick(3);
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_err", {31'd0, data_err}, 32'd0);
      check("rst_ack", {31'd0, data_ack}, 32'd0);
      check("rst_count", {29'd0, fifo_count}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;
      tick(5);

      // 1: good frame
      exp_q.push_back({1'b0, 8'h1C});
      send_frame(8'h1C, 1'b0, 1'b1);
      check("t1_count", {29'd0, fifo_count}, 32'd1);
      read_one("t1_read");
      check("t1_count_after", {29'd0, fifo_count}, 32'd0);

      // 2: parity error and stop-bit error
      exp_q.push_back({1'b1, 8'h1C});
      send_frame(8'h1C, 1'b1, 1'b1);
      exp_q.push_back({1'b1, 8'hF0});
      send_frame(8'hF0, 1'b0, 1'b0);
      check("t2_count", {29'd0, fifo_count}, 32'd2);
      read_one("t2_read_a");
      read_one("t2_read_b");

      // 3: overflow on the fifth frame
      for (int i = 1; i <= 5; i++) begin
         if (i <= DEPTH) exp_q.push_back({1'b0, 8'(i)});
         send_frame(8'(i), 1'b0, 1'b1);
      end
      check("t3_count", {29'd0, fifo_count}, 32'd4);
      check("t3_ovf", {31'd0, overflow}, 32'd1);
      for (int i = 0; i < DEPTH; i++) read_one("t3_read");
      check("t3_count_after", {29'd0, fifo_count}, 32'd0);
      check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      tick(1);
      check("t3_ovf_clr", {31'd0, overflow}, 32'd0);

      // 4: short glitch on the PS/2 clock while idle
      clk_pin = 1'b0;
      tick(2);
      clk_pin = 1'b1;
      tick(20);
      check("t4_glitch_count", {29'd0, fifo_count}, 32'd0);
      exp_q.push_back({1'b0, 8'h5A});
      send_frame(8'h5A, 1'b0, 1'b1);
      check("t4_count", {29'd0, fifo_count}, 32'd1);
      read_one("t4_read");

      // 5: held data_req drains one entry every 2 cycles
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back({1'b0, 8'(8'h10 + i)});
         send_frame(8'(8'h10 + i), 1'b0, 1'b1);
      end
      check("t5_count_full", {29'd0, fifo_count}, 32'd4);
      a0 = ack_total;
      data_req = 1'b1;
      tick(8);
      data_req = 1'b0;
      tick(2);
      check("t5_burst_acks", ack_total - a0, 32'd4);
      check("t5_count_empty", {29'd0, fifo_count}, 32'd0);
      a0 = ack_total;
      data_req = 1'b1;
      exp_q.push_back({1'b0, 8'h21});
      send_frame(8'h21, 1'b0, 1'b1);
      exp_q.push_back({1'b0, 8'h22});
      send_frame(8'h22, 1'b0, 1'b1);
      data_req = 1'b0;
      tick(2);
      check("t5_live_acks", ack_total - a0, 32'd2);
      check("t5_live_count", {29'd0, fifo_count}, 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
      // 6a: partial frame aborted by the watchdog
      send_partial(8'hAA, 4);
      data_pin = 1'b1;
      tick(TO + 10);
      check("t6_abort_count", {29'd0, fifo_count}, 32'd0);
      exp_q.push_back({1'b0, 8'h33});
      send_frame(8'h33, 1'b0, 1'b1);
      check("t6_count", {29'd0, fifo_count}, 32'd1);
      read_one("t6_read");
`endif

      // 6b: reset mid-frame with a full FIFO and overflow set
      exp_q.push_back({1'b0, 8'h44});
      send_frame(8'h44, 1'b0, 1'b1);
      read_one("t6_pre_read");
      for (int i = 0; i < 5; i++) send_frame(8'(8'h45 + i), 1'b0, 1'b1);
      check("t6_pre_count", {29'd0, fifo_count}, 32'd4);
      check("t6_pre_ovf", {31'd0, overflow}, 32'd1);
      send_partial(8'h0F, 3);
      rst_n = 1'b0;
      tick(2);
      check("t6_rst_data", {24'd0, data}, 32'd0);
      check("t6_rst_err", {31'd0, data_err}, 32'd0);
      check("t6_rst_ack", {31'd0, data_ack}, 32'd0);
      check("t6_rst_count", {29'd0, fifo_count}, 32'd0);
      check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
      data_pin = 1'b1;
      clk_pin = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      exp_q.push_back({1'b0, 8'h66});
      send_frame(8'h66, 1'b0, 1'b1);
      check("t6_post_count", {29'd0, fifo_count}, 32'd1);
      read_one("t6_post_read");

      tick(5);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
